// File: rtl/alu_core.sv
// Registered add/subtract ALU with NZCV flags and one cycle of latency.
// Defining ALU_SAT_EN makes signed overflow clamp Result to the largest or smallest signed value.
module alu_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [1:0]       S,
   output logic [WIDTH-1:0] Result,
   output logic             C,
   output logic             V,
   output logic             Z,
   output logic             N
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] bx;
   logic             ci;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [WIDTH-1:0] res_next;
   logic             z_next;
   logic             n_next;

   // Subtraction uses ~B with a carry-in: 1 for S=10, Cin for S=11.
   always_comb begin
      bx      = S[1] ? ~B : B;
      ci      = S[0] ? Cin : S[1];
      sum_ext = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
      sum     = sum_ext[WIDTH-1:0];
      cout    = sum_ext[WIDTH];
      ovf     = (A[MSB] == bx[MSB]) && (sum[MSB] != A[MSB]);
   end

`ifdef ALU_SAT_EN
   // The sign of A gives the direction of the overflow.
   always_comb begin
      res_next = sum;
      if (ovf) begin
         res_next = A[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   always_comb begin
      res_next = sum;
   end
`endif

   always_comb begin
      z_next = (res_next == '0);
      n_next = res_next[MSB];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Result <= '0;
         C      <= 1'b0;
         V      <= 1'b0;
         Z      <= 1'b0;
         N      <= 1'b0;
      end else begin
         Result <= res_next;
         C      <= cout;
         V      <= ovf;
         Z      <= z_next;
         N      <= n_next;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: reset behaviour, an op sweep, and boundary cases,
// with vectors applied back-to-back so every cycle also checks the one-cycle latency.
module tb_alu_core;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [1:0]       S;
   logic [WIDTH-1:0] Result;
   logic             C;
   logic             V;
   logic             Z;
   logic             N;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [1:0]  s;
      logic [15:0] res;
      logic [3:0]  cvzn;
   } vec_t;

   vec_t vecs[$];

   alu_core #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .Cin    (Cin),
      .S      (S),
      .Result (Result),
      .C      (C),
      .V      (V),
      .Z      (Z),
      .N      (N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [1:0] s, input logic [15:0] res,
                          input logic c, input logic v, input logic z, input logic n);
      vec_t t;
      t.a = a; t.b = b; t.cin = cin; t.s = s; t.res = res; t.cvzn = {c, v, z, n};
      vecs.push_back(t);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_result"}, 32'(Result), 32'h0);
      check({tag, "_cvzn"}, 32'({C, V, Z, N}), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      A = 16'h1234; B = 16'h4321; Cin = 1'b1; S = 2'b00;

      //        a        b        cin s      res      C  V  Z  N
      add_vec(16'h0011, 16'h1100, 0, 2'b00, 16'h1111, 0, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 0, 2'b00, 16'h0120, 0, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 0, 2'b01, 16'h0120, 0, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 0, 2'b10, 16'h0012, 1, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 0, 2'b11, 16'h0011, 1, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 1, 2'b01, 16'h0121, 0, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 1, 2'b11, 16'h0012, 1, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 1, 2'b10, 16'h0012, 1, 0, 0, 0);
      add_vec(16'h0099, 16'h0087, 1, 2'b00, 16'h0120, 0, 0, 0, 0);
      add_vec(16'h0000, 16'h0087, 0, 2'b10, 16'hFF79, 0, 0, 0, 1);
      add_vec(16'h0000, 16'h0087, 0, 2'b11, 16'hFF78, 0, 0, 0, 1);
`ifdef ALU_SAT_EN
      add_vec(16'h4000, 16'h4000, 0, 2'b00, 16'h7FFF, 0, 1, 0, 0);
`else
      add_vec(16'h4000, 16'h4000, 0, 2'b00, 16'h8000, 0, 1, 0, 1);
`endif
      add_vec(16'h4000, 16'h4000, 0, 2'b10, 16'h0000, 1, 0, 1, 0);
`ifdef ALU_SAT_EN
      add_vec(16'h7FFF, 16'h0001, 0, 2'b00, 16'h7FFF, 0, 1, 0, 0);
`else
      add_vec(16'h7FFF, 16'h0001, 0, 2'b00, 16'h8000, 0, 1, 0, 1);
`endif
      add_vec(16'h0000, 16'h0001, 0, 2'b10, 16'hFFFF, 0, 0, 0, 1);
`ifdef ALU_SAT_EN
      add_vec(16'h8000, 16'h0001, 0, 2'b10, 16'h8000, 1, 1, 0, 1);
`else
      add_vec(16'h8000, 16'h0001, 0, 2'b10, 16'h7FFF, 1, 1, 0, 0);
`endif
      add_vec(16'hFFFF, 16'h0001, 1, 2'b00, 16'h0000, 1, 0, 1, 0);
      add_vec(16'h0005, 16'h0005, 1, 2'b11, 16'h0000, 1, 0, 1, 0);
      add_vec(16'h1234, 16'h0001, 1, 2'b00, 16'h1235, 0, 0, 0, 0);

      // Reset held across edges: outputs stay cleared, Z included.
      #1;
      check_zero("reset_initial");
      @(posedge clk);
      #1;
      check_zero("reset_held");

      @(negedge clk);
      rst = 1'b0;

      // Back-to-back: each edge must show the vector presented just before it.
      for (int i = 0; i < vecs.size(); i++) begin
         A   = vecs[i].a;
         B   = vecs[i].b;
         Cin = vecs[i].cin;
         S   = vecs[i].s;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_result", i), 32'(Result), 32'(vecs[i].res));
         check($sformatf("vec%0d_cvzn", i), 32'({C, V, Z, N}), 32'(vecs[i].cvzn));
      end

      // Mid-cycle asynchronous reset with nonzero outputs (last vector left 0x1235).
      A = 16'h7000; B = 16'h0100; Cin = 1'b0; S = 2'b00;
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      check_zero("inflight_discard");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_result", 32'(Result), 32'h7100);
      check("post_reset_cvzn", 32'({C, V, Z, N}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
